sram_1p_march_bist: RTL and testbench



---
 rtl/sram_1p_march_bist.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sram_1p_march_bist.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_march_bist.sv
// -----------------------------------------------------------------------------
// sram_1p_march_bist
//   Single-port SRAM behavioural model with a built-in March C- self-test.
//   A single A_BIST_START pulse runs the full march over DEPTH words:
//     W0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0),
//     R0 up(r0), DRAIN, DONE.
//   The march takes 10*DEPTH+1 cycles and always leaves the memory all zeros.
//
// Ports
//   A_CLK            clock, everything on posedge
//   A_RST            synchronous active-high reset (memory contents kept)
//   A_ADDR           functional address (>= DEPTH: writes dropped, reads 0)
//   A_DIN / A_BM     write data / per-bit write mask (1 = write that bit)
//   A_MEN/WEN/REN    memory/write/read enables; WEN&REN is write-through
//   A_DOUT           registered read data, 1-cycle latency (BIST reads in BIST)
//   A_BIST_START     start pulse, honoured only in IDLE or DONE
//   A_BIST_BUSY      march in progress (functional inputs ignored)
//   A_BIST_DONE      march complete, sticky until next START or reset
//   A_BIST_FAIL      at least one miscompare, sticky
//   A_BIST_FAIL_ADDR address of the first miscompare
//
// Optional build macro SRAM_BIST_FAULT_INJECT_EN adds A_FI_EN / A_FI_ADDR:
//   while A_FI_EN=1, bit 0 of the word at A_FI_ADDR is stuck-at-0 on every
//   write, functional or BIST.
// -----------------------------------------------------------------------------
module sram_1p_march_bist #(
  parameter int    P_DATA_WIDTH = 24,
  parameter int    P_ADDR_WIDTH = 14,
  parameter int    DEPTH        = 256,
  parameter string INIT_FILE    = ""
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic                    A_BIST_START,
`ifdef SRAM_BIST_FAULT_INJECT_EN
  input  logic                    A_FI_EN,
  input  logic [P_ADDR_WIDTH-1:0] A_FI_ADDR,
`endif
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [P_ADDR_WIDTH:0] DEPTH_EXT = (P_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [P_ADDR_WIDTH-1:0] LAST_ADDR = P_ADDR_WIDTH'(DEPTH - 1);
  localparam logic [P_ADDR_WIDTH-1:0] ONE_ADDR  = P_ADDR_WIDTH'(1);
  localparam logic [P_DATA_WIDTH-1:0] PAT_0     = '0;
  localparam logic [P_DATA_WIDTH-1:0] PAT_1     = '1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_W0, ST_E1, ST_E2, ST_E3, ST_E4, ST_R0, ST_DRAIN, ST_DONE
  } state_e;

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];

  state_e                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;         // march address
  logic                    phase_q, phase_d;       // E1..E4: 0 = read edge, 1 = write edge
  logic                    cmp_valid_q, cmp_valid_d; // R0: a read is waiting to be compared
  logic [P_ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d; // R0: address of that pending read
  logic [P_DATA_WIDTH-1:0] dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

  logic                    mem_we;
  logic [P_DATA_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]        mem_idx;
  logic [P_DATA_WIDTH-1:0] rd_data;
  logic [P_DATA_WIDTH-1:0] merged;
  logic                    func_in_range;
  logic                    fi_en_w;
  logic [P_ADDR_WIDTH-1:0] fi_addr_w;
  logic                    hit_func, hit_bist;
  logic                    elem_up;
  logic                    cmp_en;
  logic [P_DATA_WIDTH-1:0] cmp_exp;
  logic [P_ADDR_WIDTH-1:0] cmp_at;

`ifdef SRAM_BIST_FAULT_INJECT_EN
  assign fi_en_w   = A_FI_EN;
  assign fi_addr_w = A_FI_ADDR;
`else
  assign fi_en_w   = 1'b0;
  assign fi_addr_w = '0;
`endif

  // Reads and writes share one port: the march owns it while busy.
  assign mem_idx       = busy_q ? addr_q[IDX_W-1:0] : A_ADDR[IDX_W-1:0];
  assign rd_data       = mem[mem_idx];
  assign func_in_range = {1'b0, A_ADDR} < DEPTH_EXT;
  assign merged        = (rd_data & ~A_BM) | (A_DIN & A_BM);
  assign hit_func      = fi_en_w && (A_ADDR == fi_addr_w);
  assign hit_bist      = fi_en_w && (addr_q == fi_addr_w);

  function automatic logic [P_DATA_WIDTH-1:0] stuck(input logic hit,
                                                    input logic [P_DATA_WIDTH-1:0] d);
    return hit ? (d & ~P_DATA_WIDTH'(1)) : d;
  endfunction

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    cmp_valid_d = cmp_valid_q;
    cmp_addr_d  = cmp_addr_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    elem_up     = (state_q == ST_E1) || (state_q == ST_E2);
    cmp_en      = 1'b0;
    cmp_exp     = PAT_0;
    cmp_at      = addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (A_MEN && A_WEN && func_in_range) begin
          mem_we    = 1'b1;
          mem_wdata = stuck(hit_func, merged);
        end
        if (A_MEN && A_REN) begin
          if (!func_in_range) dout_d = '0;
          else if (A_WEN)     dout_d = stuck(hit_func, merged);
          else                dout_d = rd_data;
        end
        if (A_BIST_START) begin
          state_d     = ST_W0;
          addr_d      = '0;
          phase_d     = 1'b0;
          cmp_valid_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end

      ST_W0: begin
        mem_we    = 1'b1;
        mem_wdata = stuck(hit_bist, PAT_0);
        if (addr_q == LAST_ADDR) begin
          state_d = ST_E1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ONE_ADDR;
        end
      end

      ST_E1, ST_E2, ST_E3, ST_E4: begin
        if (!phase_q) begin
          dout_d  = rd_data;
          phase_d = 1'b1;
        end else begin
          // E1/E3 expect 0 and write 1; E2/E4 expect 1 and write 0.
          cmp_en    = 1'b1;
          cmp_exp   = (state_q == ST_E1 || state_q == ST_E3) ? PAT_0 : PAT_1;
          mem_we    = 1'b1;
          mem_wdata = stuck(hit_bist, ~cmp_exp);
          phase_d   = 1'b0;
          if (elem_up && addr_q != LAST_ADDR) begin
            addr_d = addr_q + ONE_ADDR;
          end else if (!elem_up && addr_q != '0) begin
            addr_d = addr_q - ONE_ADDR;
          end else begin
            case (state_q)
              ST_E1:   begin state_d = ST_E2; addr_d = '0;        end
              ST_E2:   begin state_d = ST_E3; addr_d = LAST_ADDR; end
              ST_E3:   begin state_d = ST_E4; addr_d = LAST_ADDR; end
              default: begin state_d = ST_R0; addr_d = '0;        end
            endcase
          end
        end
      end

      ST_R0: begin
        // Pipelined: issue this address's read, check the previous one.
        dout_d      = rd_data;
        cmp_en      = cmp_valid_q;
        cmp_at      = cmp_addr_q;
        cmp_addr_d  = addr_q;
        cmp_valid_d = 1'b1;
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + ONE_ADDR;
      end

      ST_DRAIN: begin
        cmp_en      = 1'b1;
        cmp_at      = cmp_addr_q;
        cmp_valid_d = 1'b0;
        state_d     = ST_DONE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Only the first miscompare since START is recorded.
    if (cmp_en && (dout_q != cmp_exp) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_at;
    end
  end

  always_ff @(posedge A_CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (A_RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      dout_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  // NOTE: the array has no reset branch; an SRAM keeps its contents through
  // reset, and a reset loop over every word would not map onto a macro.
  always_ff @(posedge A_CLK) begin
    if (mem_we && !A_RST) mem[mem_idx] <= mem_wdata;
  end

  // Time-zero contents of the behavioural model.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign A_DOUT           = dout_q;
  assign A_BIST_BUSY      = busy_q;
  assign A_BIST_DONE      = done_q;
  assign A_BIST_FAIL      = fail_q;
  assign A_BIST_FAIL_ADDR = fail_addr_q;

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// -----------------------------------------------------------------------------
// tb_sram_1p_march_bist
//   Self-checking bench for sram_1p_march_bist (DEPTH=16). A reference model
//   expands the march notation into a flat list of per-cycle memory operations
//   and replays it; functional accesses are modelled directly on an array.
//   Outputs are compared with the model on every falling edge, plus a few
//   literal expectations from the hand-worked scenarios.
// -----------------------------------------------------------------------------
module tb_sram_1p_march_bist;

  localparam int DW = 24;
  localparam int AW = 14;
  localparam int D  = 16;
  localparam logic [DW-1:0] ZERO = '0;
  localparam logic [DW-1:0] ONES = '1;
`ifdef SRAM_BIST_FAULT_INJECT_EN
  localparam bit FI_BUILD = 1'b1;
`else
  localparam bit FI_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, men, wen, ren, start, fi_en;
  logic [AW-1:0] addr, fi_addr;
  logic [DW-1:0] din, bm;
  logic [DW-1:0] dout;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;

  always #5 clk = ~clk;

  sram_1p_march_bist #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .DEPTH(D), .INIT_FILE("")
  ) dut (
    .A_CLK(clk), .A_RST(rst), .A_ADDR(addr), .A_DIN(din), .A_BM(bm),
    .A_MEN(men), .A_WEN(wen), .A_REN(ren), .A_BIST_START(start),
`ifdef SRAM_BIST_FAULT_INJECT_EN
    .A_FI_EN(fi_en), .A_FI_ADDR(fi_addr),
`endif
    .A_DOUT(dout), .A_BIST_BUSY(busy), .A_BIST_DONE(done),
    .A_BIST_FAIL(fail), .A_BIST_FAIL_ADDR(fail_addr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef enum {OP_W, OP_R, OP_NOP} op_kind_e;
  typedef struct {
    op_kind_e      kind;
    int            a;
    logic [DW-1:0] pat;
  } op_t;

  op_t           ops[$];
  logic [DW-1:0] m_mem [D];
  logic [DW-1:0] m_dout;
  logic          m_busy, m_done, m_fail;
  int            m_fail_addr;
  bit            m_live = 1'b0;
  bit            pend;
  int            pend_a;

  initial for (int i = 0; i < D; i++) m_mem[i] = '0;

  function automatic logic [DW-1:0] fault(input int a, input logic [DW-1:0] v);
    return (FI_BUILD && fi_en && a == int'(fi_addr)) ? (v & ~DW'(1)) : v;
  endfunction

  // One march element: for each address in order, optional read then write.
  task automatic push_elem(input bit up, input bit has_r, input logic [DW-1:0] rp,
                           input bit has_w, input logic [DW-1:0] wp);
    for (int i = 0; i < D; i++) begin
      int a;
      a = up ? i : D - 1 - i;
      if (has_r) ops.push_back('{OP_R, a, rp});
      if (has_w) ops.push_back('{OP_W, a, wp});
    end
  endtask

  task automatic build_march();
    ops.delete();
    push_elem(1'b1, 1'b0, ZERO, 1'b1, ZERO);  // up (w0)
    push_elem(1'b1, 1'b1, ZERO, 1'b1, ONES);  // up (r0,w1)
    push_elem(1'b1, 1'b1, ONES, 1'b1, ZERO);  // up (r1,w0)
    push_elem(1'b0, 1'b1, ZERO, 1'b1, ONES);  // down (r0,w1)
    push_elem(1'b0, 1'b1, ONES, 1'b1, ZERO);  // down (r1,w0)
    push_elem(1'b1, 1'b1, ZERO, 1'b0, ZERO);  // up (r0)
    ops.push_back('{OP_NOP, 0, ZERO});        // drain: last compare only
  endtask

  always @(posedge clk) begin : model_step
    op_t           op;
    logic [DW-1:0] v;
    int            a;
    if (rst) begin
      m_dout = '0; m_busy = 0; m_done = 0; m_fail = 0; m_fail_addr = 0;
      pend = 0; ops.delete(); m_live = 1'b1;
    end else if (m_live) begin
      if (m_busy) begin
        op = ops.pop_front();
        // A read's result is judged on the edge after it was issued.
        if (pend && !m_fail) begin m_fail = 1; m_fail_addr = pend_a; end
        pend = 0;
        case (op.kind)
          OP_R: begin m_dout = m_mem[op.a]; pend = (m_mem[op.a] !== op.pat); pend_a = op.a; end
          OP_W: m_mem[op.a] = fault(op.a, op.pat);
          default: ;
        endcase
        if (ops.size() == 0) begin m_busy = 0; m_done = 1; end
      end else begin
        a = int'(addr);
        if (men && wen && a < D) begin
          v = fault(a, (m_mem[a] & ~bm) | (din & bm));
          m_mem[a] = v;
        end
        if (men && ren) m_dout = (a < D) ? m_mem[a] : '0;
        if (start) begin
          build_march();
          m_busy = 1; m_done = 0; m_fail = 0; m_fail_addr = 0; pend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("dout", 32'(dout), 32'(m_dout));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("fail", 32'(fail), 32'(m_fail));
      check("fail_addr", 32'(fail_addr), 32'(m_fail_addr));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic op(input logic m, input logic w, input logic r, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] b);
    men = m; wen = w; ren = r; addr = a; din = d; bm = b;
    @(posedge clk); #1;
    men = 0; wen = 0; ren = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Count cycles until BUSY drops; optionally hammer the functional inputs.
  task automatic wait_march(input bit garbage, output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (garbage) begin
        men   = 1'($urandom_range(0, 1));
        wen   = 1'($urandom_range(0, 1));
        ren   = 1'($urandom_range(0, 1));
        addr  = AW'($urandom_range(0, D - 1));
        din   = DW'($urandom);
        bm    = DW'($urandom);
        start = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1;
      n++;
    end
    men = 0; wen = 0; ren = 0; start = 0;
    if (n >= 2000) check("march_timeout", 32'(n), 32'(10 * D + 1));
  endtask

  initial begin
    int n;
    // Safety net; the real run needs only a few thousand cycles.
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; men = 0; wen = 0; ren = 0; start = 0;
    addr = '0; din = '0; bm = '0; fi_en = 0; fi_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_flags", {29'd0, busy, done, fail}, 32'h0);
    check("rst_fail_addr", 32'(fail_addr), 32'h0);

    // Plain write then read.
    op(1, 1, 0, 14'd5, 24'hABCDEF, 24'hFFFFFF);
    op(1, 0, 1, 14'd5, '0, '0);
    @(negedge clk);
    check("read_a5", 32'(dout), 32'h00ABCDEF);

    // Masked write-through, then plain read.
    op(1, 1, 1, 14'd5, 24'h000000, 24'h0000FF);
    @(negedge clk);
    check("write_through_a5", 32'(dout), 32'h00ABCD00);
    op(1, 0, 1, 14'd5, '0, '0);
    @(negedge clk);
    check("reread_a5", 32'(dout), 32'h00ABCD00);

    // Out-of-range write is dropped, read returns 0.
    op(1, 1, 0, 14'(D), 24'h123456, 24'hFFFFFF);
    op(1, 0, 1, 14'(D), '0, '0);
    @(negedge clk);
    check("oor_read", 32'(dout), 32'h0);

    // Randomized functional traffic, including out-of-range addresses.
    for (int i = 0; i < 300; i++)
      op($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         AW'($urandom_range(0, D + 3)), DW'($urandom), DW'($urandom));

    // Full march from IDLE with noise on the functional inputs.
    pulse_start();
    @(negedge clk);
    check("start_busy", 32'(busy), 32'h1);
    wait_march(1'b1, n);
    check("march1_cycles", 32'(n), 32'(10 * D + 1));
    @(negedge clk);
    check("march1_done", 32'(done), 32'h1);
    check("march1_fail", 32'(fail), 32'h0);
    for (int a = 0; a < D; a++) begin
      op(1, 0, 1, AW'(a), '0, '0);
      @(negedge clk);
      check($sformatf("post_march_word%0d", a), 32'(dout), 32'h0);
    end

    // Dirty the memory, restart from DONE, reset 40 cycles in.
    for (int i = 0; i < 40; i++)
      op(1, 1, 0, AW'($urandom_range(0, D - 1)), DW'($urandom), ONES);
    pulse_start();
    @(negedge clk);
    check("restart_done_clr", {30'd0, busy, done}, 32'h2);
    repeat (39) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_reset_flags", {29'd0, busy, done, fail}, 32'h0);

    // A fresh march after the interrupted one must be clean.
    pulse_start();
    wait_march(1'b0, n);
    check("march2_cycles", 32'(n), 32'(10 * D + 1));
    @(negedge clk);
    check("march2_done_fail", {30'd0, done, fail}, 32'h2);

`ifdef SRAM_BIST_FAULT_INJECT_EN
    fi_en = 1; fi_addr = 14'd7;
    pulse_start();
    wait_march(1'b0, n);
    @(negedge clk);
    check("fi_done_fail", {30'd0, done, fail}, 32'h3);
    check("fi_fail_addr", 32'(fail_addr), 32'h7);
    fi_en = 0;
`endif

    // Some more random traffic after DONE, then finish.
    for (int i = 0; i < 100; i++)
      op($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         AW'($urandom_range(0, D + 3)), DW'($urandom), DW'($urandom));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
